// File: rtl/cla_seq_adder_ctrl.sv
// Area-reduced WIDTH-bit add/subtract: one 4-bit carry-lookahead slice reused LSB-first,
// one nibble per clock. Optional {N,Z,C,V} flags port enabled by defining CLA_SEQ_FLAGS_EN.
module cla_seq_adder_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int unsigned NSlice = WIDTH / 4;
  localparam int unsigned IdxW   = (NSlice > 1) ? $clog2(NSlice) : 1;
  localparam int unsigned BaseW  = IdxW + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic              carry_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [BaseW-1:0]  base;
  logic [3:0]        slice_a;
  logic [3:0]        slice_b;
  logic [3:0]        slice_g;
  logic [3:0]        slice_p;
  logic [4:0]        slice_c;
  logic [3:0]        slice_sum;
  logic              last;

  assign base    = {idx_q, 2'b00};
  assign slice_a = opa_q[base +: 4];
  assign slice_b = opb_q[base +: 4];
  assign last    = (idx_q == IdxW'(NSlice - 1));

  // Carry-lookahead slice: all four carries from generate/propagate, no ripple.
  always_comb begin
    slice_g    = slice_a & slice_b;
    slice_p    = slice_a ^ slice_b;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
    slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0]) | (slice_p[1] & slice_p[0] & carry_q);
    slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1]) | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2]) | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_sum  = slice_p ^ slice_c[3:0];
  end

`ifdef CLA_SEQ_FLAGS_EN
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] full_sum;
  logic             ovf;

  // Only meaningful on the last RUN edge, when the top nibble is the one being computed.
  assign full_sum = {slice_sum, sum_q[WIDTH-5:0]};
  assign ovf      = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (full_sum[WIDTH-1] != opa_q[WIDTH-1]);
  assign flags    = flags_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
      flags_q     <= 4'b0000;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            opa_q      <= a;
            opb_q      <= sub ? ~b : b;
            carry_q    <= sub | cin;
            idx_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          sum_q[base +: 4] <= slice_sum;
          carry_q          <= slice_c[4];
          idx_q            <= last ? '0 : idx_q + IdxW'(1);
          if (last) begin
            cout_q      <= slice_c[4];
            state_q     <= StDone;
            out_valid_q <= 1'b1;
`ifdef CLA_SEQ_FLAGS_EN
            flags_q     <= {full_sum[WIDTH-1], (full_sum == '0), slice_c[4], ovf};
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
